// File: rtl/scan_mux_pkg.sv
// Shared definitions for scan_mux: mode and state encodings plus a
// width-parametrised bit-reverse used here and by the NTT address generators.
package scan_mux_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_LIN    = 2'b01;
   localparam logic [1:0] MODE_BREV   = 2'b10;

   localparam int BREV_MAX_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Reverses the low w bits of v; bits at or above w come back as zero.
   function automatic logic [BREV_MAX_W-1:0] bit_reverse(
      input logic [BREV_MAX_W-1:0] v,
      input int                    w
   );
      logic [BREV_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < BREV_MAX_W; i++) begin
         if (i < w) begin
            r[i] = v[w-1-i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/scan_mux_mux.sv
// Combinational word selector: picks word sel out of S packed N-bit words.
module mux #(
   parameter int N  = 4,
   parameter int S  = 16,
   parameter int IW = $clog2(S)
) (
   input  logic [S*N-1:0] a,
   input  logic [IW-1:0]  sel,
   output logic [N-1:0]   s
);

   logic [N-1:0] words [S];

   for (genvar i = 0; i < S; i++) begin : g_word
      assign words[i] = a[i*N +: N];
   end

   assign s = words[sel];

endmodule

// File: rtl/scan_mux.sv
// Registered, handshaked word selector with direct single-beat select and
// linear / bit-reversed scan of a captured S-word vector.
module scan_mux
   import scan_mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int S  = 16,
   parameter int IW = $clog2(S)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [S*N-1:0] a,
   input  logic [1:0]     mode,
   input  logic [IW-1:0]  sel,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [N-1:0]   s,
   output logic [IW-1:0]  s_idx,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last,
   output logic           busy
);

   state_t         state_q, state_d;
   logic [IW-1:0]  k_q, k_d;
   logic           brev_q, brev_d;
   logic [S*N-1:0] snap_q, snap_d;
   logic [N-1:0]   s_q, s_d;
   logic [IW-1:0]  s_idx_q, s_idx_d;
   logic           out_valid_q, out_valid_d;
   logic           out_last_q, out_last_d;
   logic           busy_q, busy_d;

   logic           ld;
   logic           accept;
   logic           mode_scan;
   logic [IW-1:0]  scan_idx;
   logic [S*N-1:0] mux_in;
   logic [IW-1:0]  mux_sel;
   logic [N-1:0]   mux_out;

   assign ld       = !out_valid_q || out_ready;
   assign in_ready = (state_q == IDLE) && ld;
   assign accept   = in_valid && in_ready;

   always_comb begin
      case (mode)
         MODE_DIRECT:        mode_scan = 1'b0;
         MODE_LIN, MODE_BREV: mode_scan = 1'b1;
         default:            mode_scan = 1'b0;
      endcase
   end

   assign scan_idx = brev_q ? IW'(bit_reverse(BREV_MAX_W'(k_q), IW)) : k_q;

   // During a scan the selector reads the snapshot; otherwise it reads the
   // live input, with beat 0 of a new scan always taken from index 0.
   assign mux_in  = (state_q == SCAN) ? snap_q : a;
   assign mux_sel = (state_q == SCAN) ? scan_idx : (mode_scan ? '0 : sel);

   mux #(
      .N  (N),
      .S  (S),
      .IW (IW)
   ) u_mux (
      .a   (mux_in),
      .sel (mux_sel),
      .s   (mux_out)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      brev_d      = brev_q;
      snap_d      = snap_q;
      s_d         = s_q;
      s_idx_d     = s_idx_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;

      if (ld) begin
         if (state_q == SCAN) begin
            s_d         = mux_out;
            s_idx_d     = scan_idx;
            out_valid_d = 1'b1;
            out_last_d  = (k_q == IW'(S-1));
            k_d         = k_q + 1'b1;
            if (k_q == IW'(S-1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end else if (accept) begin
            s_d         = mux_out;
            out_valid_d = 1'b1;
            if (mode_scan) begin
               snap_d     = a;
               s_idx_d    = '0;
               out_last_d = 1'b0;
               k_d        = IW'(1);
               brev_d     = (mode == MODE_BREV);
               state_d    = SCAN;
               busy_d     = 1'b1;
            end else begin
               s_idx_d    = sel;
               out_last_d = 1'b1;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         brev_q      <= 1'b0;
         snap_q      <= '0;
         s_q         <= '0;
         s_idx_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         brev_q      <= brev_d;
         snap_q      <= snap_d;
         s_q         <= s_d;
         s_idx_q     <= s_idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

   assign s         = s_q;
   assign s_idx     = s_idx_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule
